cdb_arbiter: RTL

- Shares the single common data bus (CDB) among the functional-unit result producers (ALU, branch unit, load unit, ...), one broadcast per cycle.
- Round-robin, valid/ready handshake per requester; registered CDB output feeds the reorder buffer, reservation stations and register status.
- Winning request is broadcast one cycle after its handshake.

---
 rtl/cdb_types_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr_picker.sv | 27 ++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/cdb_types_pkg.sv
// Shared CDB types: core widths and the broadcast packet carried on the common data bus.
package cdb_types;

  localparam int CDB_XLEN      = 32;
  localparam int CDB_TAG_WIDTH = 4;
  localparam int CDB_BUF_SIZE  = 16;
  localparam int CDB_N_REQ     = 3;

  typedef struct packed {
    logic [CDB_XLEN-1:0]      data;
    logic [CDB_TAG_WIDTH-1:0] rob_tag;
    logic                     exception;
    logic                     branch_mispredict;
  } cdb_packet_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req_mask at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req_mask,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             any_valid
);

  // Scan offsets 0..N_REQ-1 from ptr; each offset maps to exactly one requester.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_valid && req_mask[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N_REQ))) begin
          winner[i] = 1'b1;
          any_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin over result producers, one registered
// broadcast per cycle, one cycle after the handshake.
// Optional feature macro CDB_FLUSH_FILTER_EN: requests targeting flushed ROB
// entries are accepted and dropped without a broadcast or pointer movement.
// XLEN/TAG_WIDTH are expected to match the cdb_types packet widths.
module cdb_arbiter
  import cdb_types::*;
#(
  parameter int XLEN      = CDB_XLEN,
  parameter int TAG_WIDTH = CDB_TAG_WIDTH,
  parameter int BUF_SIZE  = CDB_BUF_SIZE,
  parameter int N_REQ     = CDB_N_REQ
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][XLEN-1:0]     req_data,
  input  logic [N_REQ-1:0][TAG_WIDTH-1:0] req_rob_tag,
  input  logic [N_REQ-1:0]               req_exception,
  input  logic [N_REQ-1:0]               req_branch_mispredict,
  input  logic [BUF_SIZE-1:0]            flush,
  output logic                           cdb_valid,
  output logic [XLEN-1:0]                cdb_data,
  output logic [TAG_WIDTH-1:0]           cdb_rob_tag,
  output logic                           cdb_exception,
  output logic                           cdb_branch_mispredict,
  output logic [N_REQ-1:0]               grant
);

  localparam int PW = ptr_width(N_REQ);

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;
  logic [N_REQ-1:0] drop_mask;
  logic [N_REQ-1:0] scan_mask;
  logic [N_REQ-1:0] win_onehot;
  logic             any_win;
  cdb_packet_t      win_pkt;
  cdb_packet_t      cdb_q;

`ifdef CDB_FLUSH_FILTER_EN
  // Results for flushed ROB entries are consumed here and never reach the bus.
  always_comb begin
    drop_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      drop_mask[i] = req_valid[i] & flush[req_rob_tag[i]];
    end
  end
`else
  // Without filtering, flushed results are broadcast and the ROB discards them.
  logic unused_flush;
  assign unused_flush = ^flush;
  assign drop_mask    = '0;
`endif

  assign scan_mask = req_valid & ~drop_mask;

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req_mask  (scan_mask),
    .ptr       (rr_ptr),
    .winner    (win_onehot),
    .any_valid (any_win)
  );

  // No handshakes are offered while reset is held.
  assign req_ready = reset ? '0 : (win_onehot | drop_mask);

  // Mux the winning requester's payload and index out of the one-hot grant.
  always_comb begin
    win_pkt = '0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        win_pkt.data              = req_data[i];
        win_pkt.rob_tag           = req_rob_tag[i];
        win_pkt.exception         = req_exception[i];
        win_pkt.branch_mispredict = req_branch_mispredict[i];
        win_idx                   = PW'(i);
      end
    end
  end

  assign next_ptr = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);

  // Broadcast stage and round-robin pointer; idle cycles clear the payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_q     <= '0;
      cdb_valid <= 1'b0;
      grant     <= '0;
      rr_ptr    <= '0;
    end else if (any_win) begin
      cdb_q     <= win_pkt;
      cdb_valid <= 1'b1;
      grant     <= win_onehot;
      rr_ptr    <= next_ptr;
    end else begin
      cdb_q     <= '0;
      cdb_valid <= 1'b0;
      grant     <= '0;
    end
  end

  assign cdb_data              = cdb_q.data;
  assign cdb_rob_tag           = cdb_q.rob_tag;
  assign cdb_exception         = cdb_q.exception;
  assign cdb_branch_mispredict = cdb_q.branch_mispredict;

endmodule
